// File: rtl/f1_pkg.sv
// Shared state encoding and light-bar constants for the F1 reaction timer.
package f1_pkg;
  typedef enum logic [2:0] {IDLE, FILL, HOLD, TIMING, DONE, FOUL} f1_rt_state_t;
  localparam logic [7:0] LIGHTS_ALL = 8'hFF;
  localparam logic [7:0] LIGHTS_OFF = 8'h00;
endpackage

// File: rtl/f1_lfsr7.sv
// Free-running 7-bit maximal-length LFSR (x^7+x^6+1), advances every clock.
// Seeded with 7'h01 so the register can never reach the all-zero lock-up state.
module f1_lfsr7 (
  input  logic       clk,
  input  logic       rst,
  output logic [6:0] out
);
  logic [6:0] lfsr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr_q <= 7'h01;
    else      lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end

  assign out = lfsr_q;
endmodule

// File: rtl/f1_reaction_timer.sv
// F1 start-light sequencer: light ramp, random hold, reaction timing, jump-start detect.
// react -> valid/time_out one clock later; no backpressure, pulses are never stalled.
module f1_reaction_timer
  import f1_pkg::*;
#(
  parameter int FILL_TICKS = 500,
  parameter int HOLD_MIN   = 200,
  parameter int TW         = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          start,
  input  logic          react,
  output logic [7:0]    data_out,
  output logic [TW-1:0] time_out,
  output logic          valid,
  output logic          jump_start,
  output logic          busy
);
  localparam int FW = (FILL_TICKS > 1) ? $clog2(FILL_TICKS) : 1;
  localparam int HW = $clog2(HOLD_MIN + 1017);

  f1_rt_state_t  state_q, state_d;
  logic [7:0]    lights_q, lights_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [TW-1:0] tim_q, tim_d;
  logic [TW-1:0] time_q, time_d;
  logic          valid_q, valid_d;
  logic [6:0]    lfsr;

  f1_lfsr7 u_lfsr (
    .clk (clk),
    .rst (rst),
    .out (lfsr)
  );

  always_comb begin
    state_d  = state_q;
    lights_d = lights_q;
    fill_d   = fill_q;
    hold_d   = hold_q;
    tim_d    = tim_q;
    time_d   = time_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE, DONE, FOUL: begin
        if (start) begin
          state_d  = FILL;
          lights_d = LIGHTS_OFF;
          fill_d   = '0;
        end
      end
      FILL: begin
        if (react) begin
          state_d = FOUL;
        end else if (tick) begin
          if (fill_q == FW'(FILL_TICKS - 1)) begin
            lights_d = {lights_q[6:0], 1'b1};
            fill_d   = '0;
            if (lights_q[6]) begin
              state_d = HOLD;
              hold_d  = HW'(HOLD_MIN) + HW'({lfsr, 3'b000});
            end
          end else begin
            fill_d = fill_q + FW'(1);
          end
        end
      end
      HOLD: begin
        // Lights-out beats a coincident react: that react is not a jump start.
        if (tick && hold_q <= HW'(1)) begin
          state_d = TIMING;
          tim_d   = '0;
        end else if (react) begin
          state_d = FOUL;
        end else if (tick) begin
          hold_d = hold_q - HW'(1);
        end
      end
      TIMING: begin
        if (react) begin
          state_d = DONE;
          time_d  = tim_q;
          valid_d = 1'b1;
        end else if (tick && tim_q != '1) begin
          tim_d = tim_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lights_q <= LIGHTS_OFF;
      fill_q   <= '0;
      hold_q   <= '0;
      tim_q    <= '0;
      time_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      lights_q <= lights_d;
      fill_q   <= fill_d;
      hold_q   <= hold_d;
      tim_q    <= tim_d;
      time_q   <= time_d;
      valid_q  <= valid_d;
    end
  end

  always_comb begin
    data_out = LIGHTS_OFF;
    case (state_q)
      FILL:       data_out = lights_q;
      HOLD, FOUL: data_out = LIGHTS_ALL;
      default:    data_out = LIGHTS_OFF;
    endcase
  end

  assign busy       = (state_q == FILL) || (state_q == HOLD) || (state_q == TIMING);
  assign jump_start = (state_q == FOUL);
  assign valid      = valid_q;
  assign time_out   = time_q;
endmodule
